rr_mux_arb: RTL

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It is the successor to the fixed 4:1 select-driven mux. It adds a round-robin arbitration mode alongside the classic externally selected mode, and a one-deep output register with back-pressure. It sits between several producer channels and a single consumer stream.

---
 rtl/mux_pkg.sv | 10 +
 rtl/rr_grant.sv | 30 +++
 rtl/rr_mux_arb.sv | 58 +++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / fixed-select output mux.
package mux_pkg;
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Channel-index width that never collapses to zero for small channel counts.
    function automatic int cw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_grant.sv
// Rotating-priority grant: the search starts one past the last served channel and wraps.
module rr_grant
    import mux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = cw_of(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  last,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  idx
);
    int  c;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= NCH; k++) begin
            c = (int'(last) + k) % NCH;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = CW'(c);
            end
        end
    end
endmodule

// File: rtl/rr_mux_arb.sv
// N-channel registered mux with valid/ready on every side; round-robin or
// externally selected arbitration feeding a one-deep output register.
module rr_mux_arb
    import mux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int CW  = cw_of(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [CW-1:0]    sel,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [CW-1:0]    out_ch,
    input  logic             out_ready
);
    logic [CW-1:0]  last;
    logic [NCH-1:0] rr_gnt, fix_gnt, gnt;
    logic [CW-1:0]  rr_idx, gidx;
    logic           load, sel_ok, take;

    rr_grant #(.NCH(NCH), .CW(CW)) u_grant (
        .req  (in_valid),
        .last (last),
        .gnt  (rr_gnt),
        .idx  (rr_idx)
    );

    assign load    = !out_valid || out_ready;
    assign sel_ok  = {1'b0, sel} < (CW+1)'(NCH);
    assign fix_gnt = sel_ok ? (in_valid & (NCH'(1) << sel)) : '0;
    assign gnt     = (mode == MODE_FIXED) ? fix_gnt : rr_gnt;
    assign gidx    = (mode == MODE_FIXED) ? sel : rr_idx;
    // Held in reset nothing is accepted, so no producer believes a word left.
    assign in_ready = (load && rst_n) ? gnt : '0;
    assign take     = |in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last      <= CW'(NCH-1);
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gidx*W +: W];
            out_ch    <= gidx;
            last      <= gidx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
